tap_accumulator: RTL

TAP_ACCUMULATOR -- requirements
Module: tap_accumulator

---
 rtl/tap_accumulator.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tap_accumulator.sv
// Accumulates NUM_TAPS signed products into a saturating accumulator, then
// rescales and saturates the sum into a registered result with a ready/valid handshake.
module tap_accumulator #(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_FRAC   = 15,
  parameter int ACC_WIDTH  = 24,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_FRAC  = 15,
  parameter int NUM_TAPS   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_valid,
  input  logic signed [DIN_WIDTH-1:0]  i_product,
  input  logic                         i_ovr,
  output logic                         o_ready,
  output logic                         o_valid,
  output logic        [DOUT_WIDTH-1:0] o_result,
  output logic                         o_ovr,
  input  logic                         i_ready,
  output logic                         o_busy
);

  localparam int CW = $clog2(NUM_TAPS + 1);
  localparam int SH = DIN_FRAC - DOUT_FRAC;
  localparam int EW = (ACC_WIDTH > DOUT_WIDTH) ? ACC_WIDTH : DOUT_WIDTH;

  localparam logic [CW-1:0]               LAST    = CW'(NUM_TAPS - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [EW-1:0]        OUT_MAX = EW'({1'b0, {(DOUT_WIDTH-1){1'b1}}});
  localparam logic signed [EW-1:0]        OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                         r_state, w_state_nxt;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic        [CW-1:0]           r_cnt;
  logic                           r_sticky;
  logic        [DOUT_WIDTH-1:0]   r_result;
  logic                           r_ovr;

  logic                           w_accept, w_last;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext, w_sum, w_acc_nxt, w_shr;
  logic                           w_add_ovf, w_sticky_nxt;
  logic signed [EW-1:0]           w_shr_ext;
  logic                           w_cvt_pos, w_cvt_neg;
  logic        [DOUT_WIDTH-1:0]   w_cvt;

  assign w_accept = (r_state == ACCUM) && i_valid;
  assign w_last   = w_accept && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = ACCUM;
      ACCUM:   if (w_last)  w_state_nxt = OUT;
      OUT:     if (i_ready) w_state_nxt = IDLE;
      default:              w_state_nxt = IDLE;
    endcase
  end

  // Overflow only possible when both addends share a sign and the sum flips it.
  always_comb begin
    w_prod_ext   = ACC_WIDTH'(i_product);
    w_sum        = r_acc + w_prod_ext;
    w_add_ovf    = (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                   (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
    w_acc_nxt    = w_add_ovf ? (r_acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : w_sum;
    w_sticky_nxt = r_sticky | i_ovr | w_add_ovf;
  end

  // Result conversion works on the post-add value so it lands in OUT without an extra cycle.
  always_comb begin
    w_shr     = w_acc_nxt >>> SH;
    w_shr_ext = EW'(w_shr);
    w_cvt_pos = w_shr_ext > OUT_MAX;
    w_cvt_neg = w_shr_ext < OUT_MIN;
    w_cvt     = w_shr_ext[DOUT_WIDTH-1:0];
    if (w_cvt_pos)      w_cvt = OUT_MAX[DOUT_WIDTH-1:0];
    else if (w_cvt_neg) w_cvt = OUT_MIN[DOUT_WIDTH-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_result <= '0;
      r_ovr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_acc    <= '0;
          r_cnt    <= '0;
          r_sticky <= 1'b0;
        end
        ACCUM: if (w_accept) begin
          r_acc    <= w_acc_nxt;
          r_cnt    <= r_cnt + CW'(1);
          r_sticky <= w_sticky_nxt;
          if (w_last) begin
            r_result <= w_cvt;
            r_ovr    <= w_sticky_nxt | w_cvt_pos | w_cvt_neg;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready  = (r_state == ACCUM);
  assign o_valid  = (r_state == OUT);
  assign o_busy   = (r_state != IDLE);
  assign o_result = r_result;
  assign o_ovr    = r_ovr;

endmodule
